// File: rtl/multi_cycle_control_if.sv
// Purpose: bundles the control unit's memory handshakes and its datapath control outputs.
// Latency: wiring only; it adds no cycles.
// Backpressure: imem_ready and dmem_ready stall the control unit while they are low.
interface multi_cycle_control_if;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_b;
    logic [2:0]  alu_op;
    logic [6:0]  op_code;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;
    logic        illegal;
    logic [2:0]  state;

    // The control unit drives the strobes and decode outputs.
    modport master (
        input  instr, imem_ready, dmem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write,
        output alu_src_b, alu_op, op_code, shamt, imm_ext, illegal, state
    );

    // The memory and datapath side supplies the instruction word and the ready signals.
    modport slave (
        output instr, imem_ready, dmem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write,
        input  alu_src_b, alu_op, op_code, shamt, imm_ext, illegal, state
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Purpose: multi-cycle RV32I-subset control FSM (IF/ID/EX/MEM/WB/HALT) with an internal IR and decode.
// Latency: ADDI/SLLI/SLT/SW take 4 cycles and LW takes 5, with both memories ready.
// Backpressure: the FSM holds in IF while imem_ready is low and holds in MEM while dmem_ready is low.
module multi_cycle_control #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic                  CLK,
    input  logic                  Reset,
    multi_cycle_control_if.master bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic        r_illegal;

    logic        w_pc_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_is_addi;
    logic        w_is_slli;
    logic        w_is_slt;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_legal;
    logic [2:0]  w_alu_op;
    logic        w_alu_src_b;
    logic [31:0] w_imm_ext;

    // The register-source fields belong to the datapath's register-file addressing, not to this FSM.
    logic        w_unused_rs1;
    assign w_unused_rs1 = ^r_ir[19:15];

    assign w_op = r_ir[6:0];
    assign w_f3 = r_ir[14:12];
    assign w_f7 = r_ir[31:25];

    // Exact-match decode: an encoding outside this set, including all-zero, is illegal.
    assign w_is_addi = (w_op == 7'b0010011) && (w_f3 == 3'b000);
    assign w_is_slli = (w_op == 7'b0010011) && (w_f3 == 3'b001) && (w_f7 == 7'b0000000);
    assign w_is_slt  = (w_op == 7'b0110011) && (w_f3 == 3'b010) && (w_f7 == 7'b0000000);
    assign w_is_lw   = (w_op == 7'b0000011) && (w_f3 == 3'b010);
    assign w_is_sw   = (w_op == 7'b0100011) && (w_f3 == 3'b010);
    assign w_legal   = w_is_addi | w_is_slli | w_is_slt | w_is_lw | w_is_sw;

    // ALU controls and the immediate depend on the IR alone, so they hold steady from ID through WB.
    always_comb begin
        w_alu_op    = 3'b000;
        w_alu_src_b = 1'b0;
        w_imm_ext   = 32'd0;
        if (w_is_addi || w_is_lw) begin
            w_alu_src_b = 1'b1;
            w_imm_ext   = {{20{r_ir[31]}}, r_ir[31:20]};
        end else if (w_is_slli) begin
            w_alu_op    = 3'b001;
            w_alu_src_b = 1'b1;
            w_imm_ext   = {{20{r_ir[31]}}, r_ir[31:20]};
        end else if (w_is_sw) begin
            w_alu_src_b = 1'b1;
            w_imm_ext   = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        end else if (w_is_slt) begin
            w_alu_op    = 3'b010;
        end
    end

    // Next state and strobes. The strobes are Moore outputs except for the IF fetch strobes, which follow imem_ready.
    always_comb begin
        w_next      = S_IF;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        case (r_state)
            S_IF: begin
                w_pc_write = bus.imem_ready;
                w_ir_write = bus.imem_ready;
                w_next     = bus.imem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                w_next = w_legal ? S_EX : S_HALT;
            end
            S_EX: begin
                w_next = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_mem_read  = w_is_lw;
                w_mem_write = w_is_sw;
                if (bus.dmem_ready) begin
                    w_next = w_is_lw ? S_WB : S_IF;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_IF;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            // Unused state codes fall back to IF on the next edge.
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // State, IR and sticky illegal flag. Reset takes priority over everything else.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= state_t'(RESET_STATE);
            r_ir      <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ir_write) begin
                r_ir <= bus.instr;
            end
            if ((r_state == S_ID) && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.ir_write  = w_ir_write;
    assign bus.reg_write = w_reg_write;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.op_code   = w_op;
    assign bus.shamt     = r_ir[24:20];
    assign bus.imm_ext   = w_imm_ext;
    assign bus.illegal   = r_illegal;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Purpose: scoreboard bench for multi_cycle_control that drives directed instruction sequences.
// Latency: it expects one scoreboard entry per clock cycle and compares each at the falling edge.
// Backpressure: it exercises imem_ready and dmem_ready stalls, and ready pulses outside IF and MEM.
module tb_multi_cycle_control;

    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    multi_cycle_control_if bus ();

    multi_cycle_control #(.RESET_STATE(3'd0)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  sh;
        logic [31:0] imm;
        logic [2:0]  aop;
        logic        srcb;
    } dec_t;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       ill;
        dec_t       d;
    } exp_t;

    // Hand-decoded fields for each instruction word used below.
    localparam dec_t D_ZERO = '{7'h00, 5'd0,  32'h0000_0000, 3'd0, 1'b0};
    localparam dec_t D_ADDI = '{7'h13, 5'd5,  32'h0000_0005, 3'd0, 1'b1}; // 0x00500093
    localparam dec_t D_SLLI = '{7'h13, 5'd3,  32'h0000_0003, 3'd1, 1'b1}; // 0x00309113
    localparam dec_t D_SLT  = '{7'h33, 5'd2,  32'h0000_0000, 3'd2, 1'b0}; // 0x0020A1B3
    localparam dec_t D_LW   = '{7'h03, 5'd28, 32'hFFFF_FFFC, 3'd0, 1'b1}; // 0xFFC02203
    localparam dec_t D_SW   = '{7'h23, 5'd1,  32'h0000_0008, 3'd0, 1'b1}; // 0x00102423

    // Strobe patterns, ordered {pc_write, ir_write, reg_write, mem_read, mem_write}.
    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] FETCH = 5'b11000;
    localparam logic [4:0] RW    = 5'b00100;
    localparam logic [4:0] MR    = 5'b00010;
    localparam logic [4:0] MW    = 5'b00001;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    int    step   = 0;
    dec_t  cur;
    dec_t  nxt;
    logic [31:0] instr_v;
    exp_t  mon_exp;
    exp_t  mon_act;

    // Monitor: compare every cycle for which the driver has queued an expectation.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_exp = q.pop_front();
            mon_act = '{bus.state, bus.pc_write, bus.ir_write, bus.reg_write,
                        bus.mem_read, bus.mem_write, bus.illegal,
                        '{bus.op_code, bus.shamt, bus.imm_ext, bus.alu_op, bus.alu_src_b}};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL step%0d: state %0d strobes %b ill %b op %h sh %0d imm %h aop %0d srcb %b | want state %0d strobes %b ill %b op %h sh %0d imm %h aop %0d srcb %b",
                         step, mon_act.st, {mon_act.pcw, mon_act.irw, mon_act.rw, mon_act.mr, mon_act.mw},
                         mon_act.ill, mon_act.d.op, mon_act.d.sh, mon_act.d.imm, mon_act.d.aop, mon_act.d.srcb,
                         mon_exp.st, {mon_exp.pcw, mon_exp.irw, mon_exp.rw, mon_exp.mr, mon_exp.mw},
                         mon_exp.ill, mon_exp.d.op, mon_exp.d.sh, mon_exp.d.imm, mon_exp.d.aop, mon_exp.d.srcb);
            end
            step++;
        end
    end

    task automatic fetch(input logic [31:0] ins, input dec_t d);
        instr_v = ins;
        nxt     = d;
    endtask

    // Drive one cycle and queue the outputs expected during it. The decode fields follow the IR,
    // which loads only on an IF cycle with imem_ready and clears on Reset.
    task automatic cyc(input logic [2:0] st, input logic imr, input logic dmr,
                       input logic rst, input logic [4:0] stb, input logic ill);
        exp_t e;
        Reset          = rst;
        bus.imem_ready = imr;
        bus.dmem_ready = dmr;
        bus.instr      = instr_v;
        e.st  = st;
        {e.pcw, e.irw, e.rw, e.mr, e.mw} = stb;
        e.ill = ill;
        e.d   = cur;
        q.push_back(e);
        @(posedge CLK);
        #1;
        if (rst) cur = D_ZERO;
        else if (st == 3'd0 && imr) cur = nxt;
    endtask

    initial begin
        Reset          = 1'b1;
        bus.instr      = 32'd0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        instr_v        = 32'd0;
        cur            = D_ZERO;
        nxt            = D_ZERO;
        @(posedge CLK);
        #1;

        // Second reset cycle, then three idle IF cycles with imem_ready low.
        cyc(3'd0, 1'b0, 1'b0, 1'b1, NONE, 1'b0);
        repeat (3) cyc(3'd0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);

        // ADDI x1,x0,5
        fetch(32'h0050_0093, D_ADDI);
        cyc(3'd0, 1'b1, 1'b1, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd2, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd4, 1'b1, 1'b1, 1'b0, RW,    1'b0);

        // SLLI
        fetch(32'h0030_9113, D_SLLI);
        cyc(3'd0, 1'b1, 1'b1, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd2, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd4, 1'b1, 1'b1, 1'b0, RW,    1'b0);

        // SLT
        fetch(32'h0020_A1B3, D_SLT);
        cyc(3'd0, 1'b1, 1'b1, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd2, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd4, 1'b1, 1'b1, 1'b0, RW,    1'b0);

        // LW x4,-4(x0), with dmem_ready low for two MEM cycles
        fetch(32'hFFC0_2203, D_LW);
        cyc(3'd0, 1'b1, 1'b0, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd2, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd3, 1'b1, 1'b0, 1'b0, MR,    1'b0);
        cyc(3'd3, 1'b1, 1'b0, 1'b0, MR,    1'b0);
        cyc(3'd3, 1'b1, 1'b1, 1'b0, MR,    1'b0);
        cyc(3'd4, 1'b1, 1'b1, 1'b0, RW,    1'b0);

        // SW x1,8(x0), which returns to IF straight from MEM
        fetch(32'h0010_2423, D_SW);
        cyc(3'd0, 1'b1, 1'b1, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd2, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd3, 1'b1, 1'b1, 1'b0, MW,    1'b0);

        // SW again, with Reset asserted during MEM
        cyc(3'd0, 1'b1, 1'b1, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd2, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd3, 1'b1, 1'b0, 1'b1, MW,    1'b0);
        cyc(3'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0);

        // All-zero word: illegal, HALT, imem_ready pulses ignored, Reset recovers
        fetch(32'h0000_0000, D_ZERO);
        cyc(3'd0, 1'b1, 1'b1, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b1, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd5, 1'b1, 1'b1, 1'b0, NONE,  1'b1);
        cyc(3'd5, 1'b0, 1'b1, 1'b0, NONE,  1'b1);
        cyc(3'd5, 1'b1, 1'b0, 1'b0, NONE,  1'b1);
        cyc(3'd5, 1'b1, 1'b1, 1'b1, NONE,  1'b1);
        cyc(3'd0, 1'b0, 1'b0, 1'b0, NONE,  1'b0);

        // Normal operation resumes after recovery: ADDI with one imem stall cycle
        fetch(32'h0050_0093, D_ADDI);
        cyc(3'd0, 1'b0, 1'b1, 1'b0, NONE,  1'b0);
        cyc(3'd0, 1'b1, 1'b1, 1'b0, FETCH, 1'b0);
        cyc(3'd1, 1'b0, 1'b0, 1'b0, NONE,  1'b0);
        cyc(3'd2, 1'b0, 1'b0, 1'b0, NONE,  1'b0);
        cyc(3'd4, 1'b0, 1'b0, 1'b0, RW,    1'b0);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
